// File: rtl/bench_bist_sequencer.sv
// BIST sequencer for one ISCAS89-style benchmark core: resets the core,
// applies N LFSR vectors and compacts the core outputs into a 16-bit MISR.
// Optional golden-signature compare is enabled by defining BIST_GOLDEN_CMP_EN
// (adds ports golden and pass).
module bench_bist_sequencer #(
  parameter int unsigned NUM_IN     = 3,
  parameter int unsigned NUM_OUT    = 6,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               blif_clk_net,
  input  logic               blif_reset_net,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_cycles,
  input  logic [15:0]        seed,
`ifdef BIST_GOLDEN_CMP_EN
  input  logic [15:0]        golden,
  output logic               pass,
`endif
  output logic               dut_rst,
  output logic [NUM_IN-1:0]  dut_in,
  input  logic [NUM_OUT-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic [15:0]        signature
);

  localparam int unsigned SIG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_DUT = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [SIG_W-1:0]   lfsr_q, lfsr_d;
  logic [SIG_W-1:0]   misr_d;
  logic               cap_en_q, cap_en_d;
  logic               dut_rst_d;
  logic [NUM_IN-1:0]  dut_in_d;
  logic               busy_d;
  logic               done_d;
`ifdef BIST_GOLDEN_CMP_EN
  logic [SIG_W-1:0]   golden_q, golden_d;
  logic               pass_d;
`endif

  // Shared shift for the LFSR and MISR: x^16+x^14+x^13+x^11+1
  function automatic logic [SIG_W-1:0] step16(input logic [SIG_W-1:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    n_d       = n_q;
    lfsr_d    = lfsr_q;
    misr_d    = signature;
    cap_en_d  = 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
    golden_d  = golden_q;
    pass_d    = pass;
`endif

    // Capture lags the applied vector by one cycle (core outputs are flopped)
    if (cap_en_q) begin
      misr_d = step16(signature) ^ SIG_W'(dut_out);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RST_DUT;
          n_d       = num_cycles;
          lfsr_d    = (seed == 16'h0000) ? 16'h0001 : seed;
          misr_d    = '0;
          counter_d = CNT_W'(RST_CYCLES - 1);
`ifdef BIST_GOLDEN_CMP_EN
          golden_d  = golden;
          pass_d    = 1'b0;
`endif
        end
      end
      ST_RST_DUT: begin
        if (abort) begin
          state_d = ST_IDLE;
`ifdef BIST_GOLDEN_CMP_EN
          pass_d  = 1'b0;
`endif
        end else if (counter_q == '0) begin
          if (n_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            counter_d = '0;
          end
        end else begin
          counter_d = counter_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
`ifdef BIST_GOLDEN_CMP_EN
          pass_d  = 1'b0;
`endif
        end else begin
          cap_en_d = 1'b1;
          lfsr_d   = step16(lfsr_q);
          if (counter_q == n_q - CNT_W'(1)) begin
            state_d = ST_FLUSH;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        state_d = abort ? ST_IDLE : ST_DONE;
`ifdef BIST_GOLDEN_CMP_EN
        pass_d  = abort ? 1'b0 : (misr_d == golden_q);
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dut_rst_d = (state_d == ST_RST_DUT);
    dut_in_d  = (state_d == ST_RUN) ? lfsr_d[NUM_IN-1:0] : '0;
    busy_d    = (state_d == ST_RST_DUT) || (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d    = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      n_q       <= '0;
      lfsr_q    <= 16'h0001;
      signature <= '0;
      cap_en_q  <= 1'b0;
      dut_rst   <= 1'b1;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
      golden_q  <= '0;
      pass      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      n_q       <= n_d;
      lfsr_q    <= lfsr_d;
      signature <= misr_d;
      cap_en_q  <= cap_en_d;
      dut_rst   <= dut_rst_d;
      dut_in    <= dut_in_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef BIST_GOLDEN_CMP_EN
      golden_q  <= golden_d;
      pass      <= pass_d;
`endif
    end
  end

endmodule

// File: tb/tb_bench_bist_sequencer.sv
// Scoreboard bench for bench_bist_sequencer with a flopped fake core.
module tb_bench_bist_sequencer;

  localparam int unsigned NI   = 3;
  localparam int unsigned NO   = 6;
  localparam int unsigned RSTC = 2;
  localparam int unsigned CW   = 16;

  logic          blif_clk_net = 1'b0;
  logic          blif_reset_net = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic [15:0]   seed = '0;
  logic [15:0]   golden = '0;
  logic          dut_rst;
  logic [NI-1:0] dut_in;
  logic [NO-1:0] dut_out;
  logic          busy;
  logic          done;
  logic [15:0]   signature;
`ifdef BIST_GOLDEN_CMP_EN
  logic          pass;
`endif

  bench_bist_sequencer #(
    .NUM_IN(NI), .NUM_OUT(NO), .RST_CYCLES(RSTC), .CNT_W(CW)
  ) dut (
    .blif_clk_net  (blif_clk_net),
    .blif_reset_net(blif_reset_net),
    .start         (start),
    .abort         (abort),
    .num_cycles    (num_cycles),
    .seed          (seed),
`ifdef BIST_GOLDEN_CMP_EN
    .golden        (golden),
    .pass          (pass),
`endif
    .dut_rst       (dut_rst),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .signature     (signature)
  );

  always #5 blif_clk_net = ~blif_clk_net;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge blif_clk_net) cyc <= cyc + 1;

  // Fake benchmark core: outputs come from flops, cleared by dut_rst
  logic [NO-1:0] core_q = '0;
  logic [NO-1:0] core_mask = '0;
  logic [NO-1:0] const_val = '0;
  bit            use_const = 1'b0;
  always @(posedge blif_clk_net) core_q <= dut_rst ? '0 : (NO'({dut_in, dut_in}) ^ core_mask);
  assign dut_out = use_const ? const_val : core_q;

  typedef struct {
    logic [15:0] sig;
    int          done_cyc;
    bit          exp_pass;
  } run_t;

  run_t          rq[$];
  logic [NI-1:0] vq[$];
  bit            mon_en = 1'b0;
  bit            done_prev = 1'b0;
  int            rst_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // Reference: vectors are successive LFSR states, signature folds the core response
  task automatic model_run(input logic [15:0] sd, input int n, input int push_lim,
                           output logic [15:0] sig);
    logic [15:0]   l;
    logic [15:0]   m;
    logic [NI-1:0] v;
    logic [NO-1:0] resp;
    l = (sd == 16'h0000) ? 16'h0001 : sd;
    m = 16'h0000;
    for (int k = 0; k < n; k++) begin
      v = l[NI-1:0];
      if (k < push_lim) vq.push_back(v);
      resp = use_const ? const_val : (NO'({v, v}) ^ core_mask);
      m = shift16(m) ^ 16'(resp);
      l = shift16(l);
    end
    if (n > 0 && push_lim > n) vq.push_back('0);
    sig = m;
  endtask

  // Monitor: checks every applied vector and every completed run
  always @(negedge blif_clk_net) begin
    run_t          r;
    logic [NI-1:0] ev;
    if (mon_en) begin
      if (busy && !dut_rst) begin
        if (vq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL vec_unexpected: got %0h expected none", dut_in);
        end else begin
          ev = vq.pop_front();
          chk("dut_in_vec", 32'(dut_in), 32'(ev));
        end
      end
      if (!busy) chk("idle_dut_in_zero", 32'(dut_in), 32'd0);
      if (busy && dut_rst) rst_cnt++;
      if (done && !done_prev) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 expected no run");
        end else begin
          r = rq.pop_front();
          chk("signature", 32'(signature), 32'(r.sig));
          chk("done_latency", 32'(cyc), 32'(r.done_cyc));
          chk("dut_rst_cycles", 32'(rst_cnt), 32'(RSTC));
`ifdef BIST_GOLDEN_CMP_EN
          chk("pass_at_done", 32'(pass), 32'(r.exp_pass));
`endif
        end
      end
      if (!busy) rst_cnt = 0;
    end
    done_prev = done;
  end

  task automatic do_run(input logic [15:0] sd, input int n, input bit uc,
                        input logic [NO-1:0] cv, input logic [NO-1:0] mk,
                        input bit busy_starts, input bit with_abort,
                        input bit g_match, input logic [15:0] g_other,
                        output logic [15:0] sig);
    run_t r;
    int   e;
    use_const = uc;
    const_val = cv;
    core_mask = mk;
    model_run(sd, n, 1000, sig);
    golden     = g_match ? sig : g_other;
    num_cycles = CW'(n);
    seed       = sd;
    start      = 1'b1;
    abort      = with_abort;
    @(posedge blif_clk_net);
    #1;
    start = 1'b0;
    abort = 1'b0;
    e = cyc;
    r.sig      = sig;
    r.done_cyc = (n == 0) ? e + int'(RSTC) : e + int'(RSTC) + n + 1;
    r.exp_pass = (golden == sig);
    rq.push_back(r);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared_on_start", 32'(done), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("pass_cleared_on_start", 32'(pass), 32'd0);
`endif
    if (busy_starts) begin
      seed       = 16'($urandom);
      num_cycles = CW'($urandom);
      start = 1'b1;
      @(posedge blif_clk_net); #1;
      start = 1'b0;
      @(posedge blif_clk_net); #1;
      start = 1'b1;
      @(posedge blif_clk_net); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n + int'(RSTC) + 20; i++) begin
      if (done) break;
      @(posedge blif_clk_net);
      #1;
    end
    chk("done_within_budget", 32'(done), 32'd1);
    @(posedge blif_clk_net);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sig;
    logic [15:0] sd;
    int          n;
    bit          bs;

    // Power-on reset
    repeat (3) @(posedge blif_clk_net);
    #1;
    chk("rst_dut_rst", 32'(dut_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_signature", 32'(signature), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("rst_pass", 32'(pass), 32'd0);
`endif
    blif_reset_net = 1'b0;
    @(posedge blif_clk_net);
    #1;
    chk("idle_dut_rst_low", 32'(dut_rst), 32'd0);
    mon_en = 1'b1;

    // Seed 1, N=4, core outputs tied low
    do_run(16'h0001, 4, 1'b1, '0, '0, 1'b0, 1'b0, 1'b1, 16'h0, sig);
    chk("tp1_signature", 32'(signature), 32'h0000);

    // Seed 0 treated as 1, N=2, constant core output 1; start+abort in DONE
    do_run(16'h0000, 2, 1'b1, 6'h01, '0, 1'b0, 1'b1, 1'b1, 16'h0, sig);
    chk("tp2_signature", 32'(signature), 32'h0003);
`ifdef BIST_GOLDEN_CMP_EN
    chk("tp2_pass_match", 32'(pass), 32'd1);
`endif
    do_run(16'h0000, 2, 1'b1, 6'h01, '0, 1'b0, 1'b0, 1'b0, 16'h0004, sig);
    chk("tp2b_signature", 32'(signature), 32'h0003);
`ifdef BIST_GOLDEN_CMP_EN
    chk("tp2_pass_mismatch", 32'(pass), 32'd0);
`endif

    // N=0: reset phase straight into DONE
    do_run(16'h5a5a, 0, 1'b0, '0, 6'h2b, 1'b0, 1'b0, 1'b1, 16'h0, sig);
    chk("tp3_signature", 32'(signature), 32'h0000);

    // Abort in RUN cycle 1 of a 10-vector run
    use_const = 1'b0;
    core_mask = NO'($urandom);
    sd = 16'($urandom);
    model_run(sd, 10, 2, sig);
    num_cycles = CW'(10);
    seed = sd;
    start = 1'b1;
    @(posedge blif_clk_net); #1;
    start = 1'b0;
    repeat (3) @(posedge blif_clk_net);
    #1;
    abort = 1'b1;
    @(posedge blif_clk_net); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dut_rst", 32'(dut_rst), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("abort_pass", 32'(pass), 32'd0);
`endif
    chk("abort_vecs_consumed", 32'(vq.size()), 32'd0);
    abort = 1'b1;
    @(posedge blif_clk_net); #1;
    abort = 1'b0;
    @(posedge blif_clk_net); #1;
    chk("idle_abort_ignored", 32'(busy), 32'd0);
    do_run(16'h0001, 4, 1'b0, '0, NO'($urandom), 1'b0, 1'b0, 1'b1, 16'h0, sig);

    // Randomized runs, some with start pulses while busy
    for (int i = 0; i < 10; i++) begin
      sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      n  = int'($urandom_range(0, 40));
      bs = (n >= 4) && ($urandom_range(0, 1) == 1);
      do_run(sd, n, 1'($urandom_range(0, 1)), NO'($urandom), NO'($urandom), bs,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), sig);
    end

    // Starts while busy, then reset asserted mid-RUN
    mon_en = 1'b0;
    num_cycles = CW'(20);
    seed = 16'h1234;
    start = 1'b1;
    @(posedge blif_clk_net); #1;
    start = 1'b0;
    @(posedge blif_clk_net); #1;
    start = 1'b1;
    @(posedge blif_clk_net); #1;
    start = 1'b0;
    repeat (3) @(posedge blif_clk_net);
    #1;
    chk("midrun_busy", 32'(busy), 32'd1);
    blif_reset_net = 1'b1;
    @(posedge blif_clk_net); #1;
    chk("midrst_dut_rst", 32'(dut_rst), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dut_in", 32'(dut_in), 32'd0);
    chk("midrst_signature", 32'(signature), 32'd0);
`ifdef BIST_GOLDEN_CMP_EN
    chk("midrst_pass", 32'(pass), 32'd0);
`endif
    @(posedge blif_clk_net); #1;
    chk("midrst_dut_rst_held", 32'(dut_rst), 32'd1);
    blif_reset_net = 1'b0;
    @(posedge blif_clk_net); #1;
    chk("postrst_dut_rst", 32'(dut_rst), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_signature", 32'(signature), 32'd0);
    vq.delete();
    rq.delete();
    @(posedge blif_clk_net); #1;
    mon_en = 1'b1;
    do_run(16'h0001, 6, 1'b0, '0, NO'($urandom), 1'b0, 1'b0, 1'b1, 16'h0, sig);

    chk("runs_drained", 32'(rq.size()), 32'd0);
    chk("vecs_drained", 32'(vq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
